// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access sequencer: launches one req/gnt/rvalid access per
// load/store, stalls the pipeline until it completes, and captures load data or errors.
module dmem_access_ctrl #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_valid_m,
  input  logic              i_mem_write,
  input  logic              i_mem_read,
  input  logic [XLEN/8-1:0] i_byte_sel,
  input  logic [XLEN-1:0]   i_addr,
  input  logic [XLEN-1:0]   i_wdata,
  output logic              o_stall,
  output logic [XLEN-1:0]   o_rdata,
  output logic              o_rdata_valid,
  output logic              o_err,
  output logic              o_req,
  output logic              o_we,
  output logic [XLEN-1:0]   o_addr,
  output logic [XLEN-1:0]   o_wdata,
  output logic [XLEN/8-1:0] o_be,
  input  logic              i_gnt,
  input  logic              i_rvalid,
  input  logic [XLEN-1:0]   i_rdata,
  input  logic              i_rerr
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_e;

  // Counter value seen in the last cycle allowed before the access is aborted
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN/8-1:0] be_q, be_d;
  logic              we_q, we_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;

  logic new_access;
  logic finish;
  logic finish_err;

  assign new_access = i_valid_m & (i_mem_read | i_mem_write) & (|i_byte_sel);

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    be_d          = be_q;
    we_d          = we_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    err_d         = 1'b0;
    cnt_d         = cnt_q;
    finish        = 1'b0;
    finish_err    = 1'b0;

    case (state_q)
      IDLE: begin
        if (new_access) begin
          addr_d  = i_addr;
          wdata_d = i_wdata;
          be_d    = i_byte_sel;
          we_d    = i_mem_write;
          cnt_d   = '0;
          state_d = REQ;
        end
      end

      REQ, WAIT: begin
        // A response only counts once the request has been granted
        if (i_rvalid & ((state_q == WAIT) | i_gnt)) begin
          finish     = 1'b1;
          finish_err = i_rerr;
        end else if (cnt_q == TimeoutLast) begin
          finish     = 1'b1;
          finish_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if ((state_q == REQ) && i_gnt) begin
            state_d = WAIT;
          end
        end

        if (finish) begin
          state_d = DONE;
          err_d   = finish_err;
          // Loads always hand writeback a defined value, zero when the access failed
          if (!we_q) begin
            rdata_valid_d = 1'b1;
            rdata_d       = finish_err ? '0 : i_rdata;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      be_q          <= '0;
      we_q          <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      err_q         <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      be_q          <= be_d;
      we_q          <= we_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      err_q         <= err_d;
      cnt_q         <= cnt_d;
    end
  end

  assign o_req         = (state_q == REQ);
  assign o_stall       = ((state_q == IDLE) & new_access) | (state_q == REQ) | (state_q == WAIT);
  assign o_we          = we_q;
  assign o_addr        = addr_q;
  assign o_wdata       = wdata_q;
  assign o_be          = be_q;
  assign o_rdata       = rdata_q;
  assign o_rdata_valid = rdata_valid_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: a scripted memory responder answers requests,
// and load/error results are queued at launch and compared when the DUT reports them.
module tb_dmem_access_ctrl;

  localparam int TO = 8;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        chk_valid;
  } sb_entry_t;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic        i_valid_m, i_mem_write, i_mem_read;
  logic [3:0]  i_byte_sel;
  logic [31:0] i_addr, i_wdata;
  logic        o_stall, o_rdata_valid, o_err, o_req, o_we;
  logic [31:0] o_rdata, o_addr, o_wdata;
  logic [3:0]  o_be;
  logic        i_gnt, i_rvalid, i_rerr;
  logic [31:0] i_rdata;

  int pass_cnt = 0;
  int check_cnt = 0;

  sb_entry_t sb[$];
  sb_entry_t mon_e;

  // memory responder configuration, written by the main sequence
  int          mem_gnt_delay = 0;
  int          mem_rvalid_delay = 0;
  logic        mem_never_gnt = 1'b0;
  logic        mem_early_rvalid = 1'b0;
  logic        mem_err = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        force_gnt = 1'b0;
  int          req_age = 0;
  int          pending = 0;

  // expected request fields while o_req is high
  logic [31:0] exp_addr = 32'h0, exp_wdata = 32'h0;
  logic [3:0]  exp_be = 4'h0;
  logic        exp_we = 1'b0;
  logic [31:0] model_rdata = 32'h0;

  // monitor statistics
  int   cyc = 0, stall_cycles = 0, req_cycles = 0, req_rises = 0;
  int   last_rise = 0, rise_gap = 0;
  logic req_prev = 1'b0;

  dmem_access_ctrl #(.XLEN(32), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_valid_m(i_valid_m),
    .i_mem_write(i_mem_write), .i_mem_read(i_mem_read), .i_byte_sel(i_byte_sel),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_stall(o_stall), .o_rdata(o_rdata),
    .o_rdata_valid(o_rdata_valid), .o_err(o_err), .o_req(o_req), .o_we(o_we),
    .o_addr(o_addr), .o_wdata(o_wdata), .o_be(o_be), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rerr(i_rerr)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
  endtask

  // Memory model: grants after mem_gnt_delay REQ cycles, responds mem_rvalid_delay cycles later
  always @(negedge i_clk) begin
    if (!i_rstn) begin
      req_age = 0; pending = 0;
      i_gnt = 1'b0; i_rvalid = 1'b0; i_rerr = 1'b0; i_rdata = 32'hA5A5A5A5;
    end else begin
      i_gnt = 1'b0; i_rvalid = 1'b0; i_rerr = 1'b0; i_rdata = 32'hA5A5A5A5;
      if (o_req) begin
        if (mem_early_rvalid && req_age == 0 && mem_gnt_delay > 0) begin
          i_rvalid = 1'b1; i_rerr = 1'b1;
        end
        if (!mem_never_gnt && req_age == mem_gnt_delay) begin
          i_gnt = 1'b1;
          if (mem_rvalid_delay == 0) begin
            i_rvalid = 1'b1; i_rerr = mem_err; i_rdata = mem_rdata;
          end else begin
            pending = mem_rvalid_delay;
          end
        end
        req_age++;
      end else begin
        req_age = 0;
        if (pending > 0) begin
          pending--;
          if (pending == 0) begin
            i_rvalid = 1'b1; i_rerr = mem_err; i_rdata = mem_rdata;
          end
        end
      end
      if (force_gnt) i_gnt = 1'b1;
    end
  end

  // Monitor: request stability, statistics, and scoreboard pops on result pulses
  always @(negedge i_clk) begin
    if (!i_rstn) begin
      req_prev = 1'b0;
    end else begin
      cyc++;
      if (o_stall) stall_cycles++;
      if (o_req) begin
        req_cycles++;
        checkOutput("req_addr", o_addr, exp_addr);
        checkOutput("req_wdata", o_wdata, exp_wdata);
        checkOutput("req_be", {28'd0, o_be}, {28'd0, exp_be});
        checkOutput("req_we", {31'd0, o_we}, {31'd0, exp_we});
        if (!req_prev) begin
          req_rises++;
          rise_gap = cyc - last_rise;
          last_rise = cyc;
        end
      end
      req_prev = o_req;
      if (o_rdata_valid || o_err) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_event", {30'd0, o_err, o_rdata_valid}, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("resp_err", {31'd0, o_err}, {31'd0, mon_e.err});
          checkOutput("resp_rdata", o_rdata, mon_e.data);
          if (mon_e.chk_valid) checkOutput("resp_valid", {31'd0, o_rdata_valid}, 32'd1);
        end
      end
    end
  end

  // Drives one MEM-stage instruction, holds it until the DUT releases the stall, then checks counts
  task automatic applyStimulus(input logic rd, input logic wr, input logic [3:0] be,
                               input logic [31:0] addr, input logic [31:0] wdata);
    int base_stall, base_req, base_rise, want_stall, want_req;
    sb_entry_t e;
    @(posedge i_clk); #1;
    i_valid_m = 1'b1; i_mem_read = rd; i_mem_write = wr;
    i_byte_sel = be; i_addr = addr; i_wdata = wdata;
    exp_addr = addr; exp_wdata = wdata; exp_be = be; exp_we = wr;
    base_stall = stall_cycles; base_req = req_cycles; base_rise = req_rises;
    if (mem_never_gnt) begin
      want_req = TO;
      want_stall = 1 + TO;
    end else begin
      want_req = mem_gnt_delay + 1;
      want_stall = 1 + want_req + mem_rvalid_delay;
    end
    if (!wr) begin
      e.err = mem_err | mem_never_gnt;
      e.data = e.err ? 32'h0 : mem_rdata;
      e.chk_valid = !mem_never_gnt;
      model_rdata = e.data;
      sb.push_back(e);
    end
    for (int k = 0; k < 60; k++) begin
      @(negedge i_clk);
      if (!o_stall) break;
    end
    #1;
    checkOutput("stall_released", {31'd0, o_stall}, 32'd0);
    checkOutput("stall_cycles", stall_cycles - base_stall, want_stall);
    checkOutput("req_cycles", req_cycles - base_req, want_req);
    checkOutput("req_launches", req_rises - base_rise, 1);
    checkOutput("rdata_hold", o_rdata, model_rdata);
  endtask

  // Presents a non-launching instruction for n cycles and checks nothing happens
  task automatic idleCycles(input logic valid, input logic rd, input logic [3:0] be, input int n);
    int base_stall, base_req;
    @(posedge i_clk); #1;
    i_valid_m = valid; i_mem_read = rd; i_mem_write = 1'b0; i_byte_sel = be;
    i_addr = 32'h0000_0FF0; i_wdata = 32'h0;
    base_stall = stall_cycles; base_req = req_cycles;
    repeat (n) @(negedge i_clk);
    #1;
    checkOutput("idle_stall", stall_cycles - base_stall, 0);
    checkOutput("idle_req", req_cycles - base_req, 0);
  endtask

  task automatic setMem(input int gd, input int rd, input logic err, input logic [31:0] data);
    mem_gnt_delay = gd; mem_rvalid_delay = rd; mem_err = err; mem_rdata = data;
    mem_never_gnt = 1'b0; mem_early_rvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_rstn = 1'b0; i_valid_m = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
    i_byte_sel = 4'h0; i_addr = 32'h0; i_wdata = 32'h0;
    repeat (3) @(negedge i_clk);
    checkOutput("rst_req", {31'd0, o_req}, 32'd0);
    checkOutput("rst_stall", {31'd0, o_stall}, 32'd0);
    checkOutput("rst_rdata", o_rdata, 32'd0);
    checkOutput("rst_valid_err", {30'd0, o_rdata_valid, o_err}, 32'd0);
    checkOutput("rst_addr", o_addr, 32'd0);
    checkOutput("rst_we", {31'd0, o_we}, 32'd0);
    i_rstn = 1'b1;

    $display("[TB] zero-wait load");
    setMem(0, 0, 1'b0, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h100, 32'h0);

    $display("[TB] store with wait states and an early rvalid before grant");
    setMem(2, 3, 1'b0, 32'hFFFFFFFF);
    mem_early_rvalid = 1'b1;
    applyStimulus(1'b0, 1'b1, 4'b0011, 32'h204, 32'h12345678);

    $display("[TB] back-to-back loads");
    setMem(0, 0, 1'b0, 32'h11111111);
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
    mem_rdata = 32'h22222222;
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
    checkOutput("b2b_gap", rise_gap, 3);

    $display("[TB] read and write together behave as a store");
    setMem(1, 1, 1'b0, 32'h33333333);
    applyStimulus(1'b1, 1'b1, 4'b1100, 32'h40, 32'hCAFEF00D);

    $display("[TB] non-memory instruction and empty byte select");
    idleCycles(1'b1, 1'b0, 4'hF, 3);
    idleCycles(1'b1, 1'b1, 4'h0, 3);
    idleCycles(1'b0, 1'b1, 4'hF, 2);

    $display("[TB] bus error on load");
    setMem(0, 2, 1'b1, 32'h55555555);
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h80, 32'h0);

    $display("[TB] timeout then late grant");
    setMem(0, 0, 1'b0, 32'h66666666);
    mem_never_gnt = 1'b1;
    applyStimulus(1'b1, 1'b0, 4'hF, 32'hC0, 32'h0);
    idleCycles(1'b0, 1'b0, 4'h0, 1);
    force_gnt = 1'b1;
    idleCycles(1'b0, 1'b0, 4'h0, 1);
    force_gnt = 1'b0;
    idleCycles(1'b0, 1'b0, 4'h0, 3);
    checkOutput("late_gnt_err", {31'd0, o_err}, 32'd0);
    checkOutput("late_gnt_rdata", o_rdata, 32'd0);

    $display("[TB] reset during WAIT");
    setMem(0, 1, 1'b0, 32'h77777777);
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    setMem(0, 10, 1'b0, 32'h88888888);
    @(posedge i_clk); #1;
    i_valid_m = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0; i_byte_sel = 4'hF;
    i_addr = 32'h300; i_wdata = 32'h0;
    exp_addr = 32'h300; exp_wdata = 32'h0; exp_be = 4'hF; exp_we = 1'b0;
    repeat (3) @(negedge i_clk);
    checkOutput("wait_stall", {31'd0, o_stall}, 32'd1);
    checkOutput("wait_req", {31'd0, o_req}, 32'd0);
    #2;
    i_rstn = 1'b0; i_valid_m = 1'b0;
    #1;
    checkOutput("midrst_req", {31'd0, o_req}, 32'd0);
    checkOutput("midrst_stall", {31'd0, o_stall}, 32'd0);
    checkOutput("midrst_rdata", o_rdata, 32'd0);
    sb.delete();
    model_rdata = 32'h0;
    repeat (2) @(negedge i_clk);
    i_rstn = 1'b1;
    setMem(0, 0, 1'b0, 32'h0BADF00D);
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h304, 32'h0);
    idleCycles(1'b0, 1'b0, 4'h0, 2);

    checkOutput("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
